// File: rtl/ec_result_fifo10_if.sv
// Producer/consumer bundle for the EC result FIFO: corrected word in, queued word out.
interface ec_result_fifo10_if #(
   parameter int DATA_WIDTH = 18
);
   logic                      in_valid;
   logic [10*DATA_WIDTH-1:0]  in_dig;
   logic [19:0]               in_err;
   logic                      in_cor_error;
   logic                      in_non_cor_error;
   logic                      in_mal_error;
   logic                      out_valid;
   logic                      out_ready;
   logic [10*DATA_WIDTH-1:0]  out_dig;
   logic [2:0]                out_status;

   modport master (
      output in_valid, in_dig, in_err, in_cor_error, in_non_cor_error, in_mal_error, out_ready,
      input  out_valid, out_dig, out_status
   );

   modport slave (
      input  in_valid, in_dig, in_err, in_cor_error, in_non_cor_error, in_mal_error, out_ready,
      output out_valid, out_dig, out_status
   );
endinterface

// File: rtl/ec_result_fifo10.sv
// Result FIFO behind the residue error-correction stage, with event counters and alarm FSM.
// Optional EC_DROP_UNCOR_EN: uncorrectable/malicious words are counted and alarmed but never queued.
module ec_result_fifo10 #(
   parameter int DATA_WIDTH = 18,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ec_result_fifo10_if.slave       bus,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   output logic [CNT_WIDTH-1:0]    cnt_cor,
   output logic [CNT_WIDTH-1:0]    cnt_noncor,
   output logic [CNT_WIDTH-1:0]    cnt_mal,
   input  logic                    clr_cnt,
   output logic                    err_irq,
   input  logic                    irq_ack
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int DIG_W  = 10 * DATA_WIDTH;
   localparam int WORD_W = DIG_W + 3;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ALARM = 1'b1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic ev);
      return (ev && (c != '1)) ? c + CNT_WIDTH'(1) : c;
   endfunction

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              full, uncor, accept, wr_en, rd_en;
   logic              ev_cor, ev_noncor, ev_mal, trig;
   logic [0:0]        state, state_nxt;

   assign full   = (level == LVL_W'(DEPTH));
   assign uncor  = bus.in_non_cor_error | bus.in_mal_error;
`ifdef EC_DROP_UNCOR_EN
   assign accept = bus.in_valid & ~uncor;
`else
   assign accept = bus.in_valid;
`endif
   assign wr_en  = accept & ~full;
   assign rd_en  = bus.out_valid & bus.out_ready;

   // A nonzero per-digit code without the word-level cor flag is still a correction event.
   assign ev_cor    = bus.in_valid & (bus.in_cor_error | (|bus.in_err));
   assign ev_noncor = bus.in_valid & bus.in_non_cor_error;
   assign ev_mal    = bus.in_valid & bus.in_mal_error;
   assign trig      = bus.in_valid & uncor;

   assign bus.out_valid  = (level != '0);
   assign bus.out_dig    = bus.out_valid ? mem[rd_ptr][WORD_W-1:3] : '0;
   assign bus.out_status = bus.out_valid ? mem[rd_ptr][2:0] : '0;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {bus.in_dig, bus.in_mal_error, bus.in_non_cor_error, bus.in_cor_error};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Full is judged on the current level, so a concurrent read never makes room for the incoming word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf        <= 1'b0;
         cnt_cor    <= '0;
         cnt_noncor <= '0;
         cnt_mal    <= '0;
      end else if (clr_cnt) begin
         ovf        <= 1'b0;
         cnt_cor    <= '0;
         cnt_noncor <= '0;
         cnt_mal    <= '0;
      end else begin
         if (accept && full) ovf <= 1'b1;
         cnt_cor    <= sat_inc(cnt_cor, ev_cor);
         cnt_noncor <= sat_inc(cnt_noncor, ev_noncor);
         cnt_mal    <= sat_inc(cnt_mal, ev_mal);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trig) state_nxt = ALARM;
         ALARM:   if (irq_ack && !trig) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign err_irq = (state == ALARM);
endmodule
